// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mult_pkg
//  Brief    : Shared types and constants for the multiplier datapath and the
//             accumulator that consumes its products.
//  Revision : 1.0 - initial release
// ============================================================================
package mult_pkg;

  // Default widths, shared with the multiplier wrapper
  localparam int MULT_PROD_W = 64;
  localparam int MULT_ACC_W  = 64;

  // Saturation limits of a MULT_ACC_W-bit signed accumulator
  localparam logic [MULT_ACC_W-1:0] ACC_MAX = {1'b0, {(MULT_ACC_W-1){1'b1}}};
  localparam logic [MULT_ACC_W-1:0] ACC_MIN = {1'b1, {(MULT_ACC_W-1){1'b0}}};

  // Accumulator control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/sat_add64.sv
`default_nettype none
// ============================================================================
//  Module   : sat_add64
//  Brief    : Combinational signed saturating adder. The sum is formed one
//             bit wider than the operands; a disagreement between the two top
//             bits means the true result is out of range and is clamped.
//  Revision : 1.0 - initial release
// ============================================================================
module sat_add64
  import mult_pkg::*;
#(
  parameter int W = MULT_ACC_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         sat
);

  localparam logic [W-1:0] C_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] C_MIN = {1'b1, {(W-1){1'b0}}};

  logic [W:0] w_full;
  logic       w_out_of_range;

  assign w_full         = {a[W-1], a} + {b[W-1], b};
  assign w_out_of_range = w_full[W] ^ w_full[W-1];

  // Pass the in-range sum through, otherwise clamp toward the sign of the true result
  always_comb begin
    sum = w_full[W-1:0];
    if (w_out_of_range) begin
      sum = w_full[W] ? C_MIN : C_MAX;
    end
  end

  assign sat = w_out_of_range;

endmodule : sat_add64
`default_nettype wire

// File: rtl/mult_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : mult_accumulator
//  Brief    : Accumulates a programmed number of signed products from the
//             multiplier into a saturating sum, then holds the result on a
//             valid/ready output until the consumer takes it.
//  Revision : 1.0 - initial release
// ============================================================================
module mult_accumulator
  import mult_pkg::*;
#(
  parameter int PROD_W = MULT_PROD_W,
  parameter int ACC_W  = MULT_ACC_W,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              ovf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [LEN_W-1:0]  count
);

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic               r_ovf;
  logic [LEN_W-1:0]   r_count;
  logic [LEN_W-1:0]   r_len;

  logic [ACC_W-1:0]   w_prod_ext;
  logic [ACC_W-1:0]   w_sum;
  logic               w_sat;
  logic [LEN_W-1:0]   w_count_nxt;
  logic               w_prod_xfer;

  // Products are two's complement, so widen with sign extension
  assign w_prod_ext  = ACC_W'($signed(prod_in));
  assign w_count_nxt = r_count + LEN_W'(1);
  assign w_prod_xfer = prod_valid & prod_ready;

  sat_add64 #(
    .W (ACC_W)
  ) u_sat_add (
    .a   (r_acc),
    .b   (w_prod_ext),
    .sum (w_sum),
    .sat (w_sat)
  );

  // Control FSM together with the accumulator, overflow flag, count and length
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_count <= '0;
      r_len   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_len   <= len;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_count <= '0;
            // A zero-length job has nothing to sum and reports zero at once
            r_state <= (len == '0) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (w_prod_xfer) begin
            r_acc   <= w_sum;
            r_ovf   <= r_ovf | w_sat;
            r_count <= w_count_nxt;
            if (w_count_nxt == r_len) begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          // Result stays put until accepted; the sum survives into IDLE
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign prod_ready = (r_state == ACCUM);
  assign out_valid  = (r_state == DONE);
  assign busy       = (r_state != IDLE);
  assign acc_out    = r_acc;
  assign ovf        = r_ovf;
  assign count      = r_count;

endmodule : mult_accumulator
`default_nettype wire

// File: tb/tb_mult_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_accumulator
//  Brief    : Self-checking bench for mult_accumulator. A reference model
//             tracks the saturating sum as products are driven and pushes the
//             expected result to a scoreboard queue; each scenario pops and
//             compares when the DUT presents its result.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_accumulator;
  import mult_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic [63:0] prod_in;
  logic        prod_valid;
  logic        prod_ready;
  logic [63:0] acc_out;
  logic        ovf;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic [7:0]  count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] acc;
    logic        ovf;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] m_acc;
  logic        m_ovf;
  logic [7:0]  m_cnt;

  mult_accumulator #(
    .PROD_W (64),
    .ACC_W  (64),
    .LEN_W  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .prod_in    (prod_in),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .acc_out    (acc_out),
    .ovf        (ovf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .count      (count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic void model_start();
    m_acc = '0;
    m_ovf = 1'b0;
    m_cnt = '0;
  endfunction

  // Overflow detected by the operand/result sign rule
  function automatic void model_add(input logic [63:0] p);
    logic [63:0] s;
    s = m_acc + p;
    if ((m_acc[63] == p[63]) && (s[63] != p[63])) begin
      m_ovf = 1'b1;
      s     = p[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
    end
    m_acc = s;
    m_cnt = m_cnt + 8'd1;
  endfunction

  function automatic void model_push();
    exp_t e;
    e.acc = m_acc;
    e.ovf = m_ovf;
    e.cnt = m_cnt;
    sb.push_back(e);
  endfunction

  // ---------------- stimulus helpers (drive at negedge) ----------------
  task automatic do_start(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
    model_start();
  endtask

  task automatic send(input logic [63:0] p);
    prod_in    = p;
    prod_valid = 1'b1;
    @(negedge clk);
    prod_valid = 1'b0;
    model_add(p);
  endtask

  task automatic collect(input int budget, output logic got, output logic [63:0] a,
                         output logic o, output logic [7:0] c);
    got = 1'b0;
    a   = '0;
    o   = 1'b0;
    c   = '0;
    for (int i = 0; i < budget; i++) begin
      if (out_valid) begin
        got = 1'b1;
        a   = acc_out;
        o   = ovf;
        c   = count;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({acc_out, ovf, count, out_valid, prod_ready, busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs acc=%h ovf=%b cnt=%0d ov=%b pr=%b busy=%b required all zero",
               acc_out, ovf, count, out_valid, prod_ready, busy);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic got, o; logic [63:0] a; logic [7:0] c; exp_t e;
    do_start(8'd3);
    total++;
    if ({busy, prod_ready, out_valid} !== 3'b110) begin
      bad++;
      $display("FAIL basic_accum_flags got=%b%b%b required 110", busy, prod_ready, out_valid);
    end
    send(64'd5);
    send(-64'sd2);
    send(64'd10);
    model_push();
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL basic_latency out_valid=%b required 1 one cycle after last transfer", out_valid);
    end
    collect(4, got, a, o, c);
    e = sb.pop_front();
    total++;
    if ({got, a, o, c} !== {1'b1, e.acc, e.ovf, e.cnt} || a !== 64'd13) begin
      bad++;
      $display("FAIL basic_result got=%b acc=%h ovf=%b cnt=%0d required acc=%h ovf=%b cnt=%0d",
               got, a, o, c, e.acc, e.ovf, e.cnt);
    end
    accept();
  endtask

  task automatic test_backpressure();
    logic got, o; logic [63:0] a; logic [7:0] c; exp_t e;
    do_start(8'd2);
    send(64'd7);
    repeat (2) @(negedge clk);
    send(64'd8);
    model_push();
    e = sb.pop_front();
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({out_valid, acc_out, count} !== {1'b1, e.acc, e.cnt}) begin
        bad++;
        $display("FAIL backpressure_hold cyc=%0d ov=%b acc=%h cnt=%0d required ov=1 acc=%h cnt=%0d",
                 i, out_valid, acc_out, count, e.acc, e.cnt);
      end
      @(negedge clk);
    end
    collect(2, got, a, o, c);
    total++;
    if ({got, a, o, c} !== {1'b1, e.acc, e.ovf, e.cnt} || a !== 64'd15) begin
      bad++;
      $display("FAIL backpressure_result got=%b acc=%h ovf=%b cnt=%0d required acc=%h", got, a, o, c, e.acc);
    end
    accept();
    total++;
    if ({out_valid, busy} !== 2'b00) begin
      bad++;
      $display("FAIL backpressure_release ov=%b busy=%b required 00", out_valid, busy);
    end
  endtask

  task automatic test_saturation();
    logic got, o; logic [63:0] a; logic [7:0] c; exp_t e;
    do_start(8'd3);
    send(64'h7FFF_FFFF_FFFF_FFF0);
    send(64'h20);
    send(-64'sh10);
    model_push();
    collect(4, got, a, o, c);
    e = sb.pop_front();
    total++;
    if ({got, a, o, c} !== {1'b1, e.acc, e.ovf, e.cnt} || a !== 64'h7FFF_FFFF_FFFF_FFEF || o !== 1'b1) begin
      bad++;
      $display("FAIL sat_pos got=%b acc=%h ovf=%b cnt=%0d required acc=%h ovf=%b", got, a, o, c, e.acc, e.ovf);
    end
    accept();
    do_start(8'd2);
    send(64'h8000_0000_0000_0010);
    send(-64'sh20);
    model_push();
    collect(4, got, a, o, c);
    e = sb.pop_front();
    total++;
    if ({got, a, o, c} !== {1'b1, e.acc, e.ovf, e.cnt} || a !== ACC_MIN || o !== 1'b1) begin
      bad++;
      $display("FAIL sat_neg got=%b acc=%h ovf=%b cnt=%0d required acc=%h ovf=%b", got, a, o, c, e.acc, e.ovf);
    end
    accept();
  endtask

  task automatic test_len0();
    logic got, o; logic [63:0] a; logic [7:0] c; exp_t e;
    // leave a stale non-zero sum behind to prove the start clears it
    do_start(8'd1);
    send(64'd99);
    accept();
    do_start(8'd0);
    model_push();
    total++;
    if ({out_valid, prod_ready} !== 2'b10) begin
      bad++;
      $display("FAIL len0_state ov=%b pr=%b required 10", out_valid, prod_ready);
    end
    collect(1, got, a, o, c);
    e = sb.pop_front();
    total++;
    if ({got, a, o, c} !== {1'b1, e.acc, e.ovf, e.cnt}) begin
      bad++;
      $display("FAIL len0_result got=%b acc=%h ovf=%b cnt=%0d required zero", got, a, o, c);
    end
    accept();
  endtask

  task automatic test_reset_mid();
    logic got, o; logic [63:0] a; logic [7:0] c; exp_t e;
    do_start(8'd4);
    send(64'd11);
    send(64'd22);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({acc_out, ovf, count, out_valid, prod_ready, busy} !== '0) begin
      bad++;
      $display("FAIL reset_mid_async acc=%h cnt=%0d busy=%b pr=%b required all zero",
               acc_out, count, busy, prod_ready);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, out_valid} !== 2'b00) begin
      bad++;
      $display("FAIL reset_mid_idle busy=%b ov=%b required 00", busy, out_valid);
    end
    do_start(8'd1);
    send(-64'sd9);
    model_push();
    collect(4, got, a, o, c);
    e = sb.pop_front();
    total++;
    if ({got, a, o, c} !== {1'b1, e.acc, e.ovf, e.cnt} || a !== 64'hFFFF_FFFF_FFFF_FFF7) begin
      bad++;
      $display("FAIL reset_mid_restart got=%b acc=%h cnt=%0d required acc=%h", got, a, c, e.acc);
    end
    accept();
  endtask

  task automatic test_ignored_start();
    logic got, o; logic [63:0] a; logic [7:0] c; exp_t e;
    do_start(8'd3);
    send(64'd1);
    start = 1'b1;
    len   = 8'd7;
    send(64'd2);
    start = 1'b0;
    total++;
    if ({busy, count} !== {1'b1, 8'd2}) begin
      bad++;
      $display("FAIL ignstart_accum busy=%b cnt=%0d required busy=1 cnt=2", busy, count);
    end
    send(64'd3);
    model_push();
    collect(4, got, a, o, c);
    e = sb.pop_front();
    total++;
    if ({got, a, o, c} !== {1'b1, e.acc, e.ovf, e.cnt}) begin
      bad++;
      $display("FAIL ignstart_result got=%b acc=%h cnt=%0d required acc=%h cnt=%0d", got, a, c, e.acc, e.cnt);
    end
    // start coincides with the result transfer and must be dropped
    start     = 1'b1;
    len       = 8'd1;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if ({busy, out_valid, acc_out, count} !== {2'b00, e.acc, e.cnt}) begin
      bad++;
      $display("FAIL ignstart_done busy=%b ov=%b acc=%h cnt=%0d required idle holding acc=%h",
               busy, out_valid, acc_out, count, e.acc);
    end
    // start still high: taken now from IDLE
    @(negedge clk);
    start = 1'b0;
    model_start();
    total++;
    if ({busy, count, acc_out} !== {1'b1, 8'd0, 64'd0}) begin
      bad++;
      $display("FAIL ignstart_next busy=%b cnt=%0d acc=%h required busy=1 cnt=0 acc=0", busy, count, acc_out);
    end
    send(64'd4);
    model_push();
    collect(4, got, a, o, c);
    e = sb.pop_front();
    total++;
    if ({got, a, o, c} !== {1'b1, e.acc, e.ovf, e.cnt}) begin
      bad++;
      $display("FAIL ignstart_second got=%b acc=%h cnt=%0d required acc=%h cnt=%0d", got, a, c, e.acc, e.cnt);
    end
    accept();
  endtask

  task automatic test_back_to_back();
    logic got, o; logic [63:0] a; logic [7:0] c; exp_t e;
    logic [63:0] p;
    do_start(8'd255);
    for (int i = 0; i < 255; i++) begin
      p = {$urandom, $urandom};
      if (i % 3 != 0) p = {{40{p[23]}}, p[23:0]};
      send(p);
    end
    model_push();
    collect(4, got, a, o, c);
    e = sb.pop_front();
    total++;
    if ({got, a, o, c} !== {1'b1, e.acc, e.ovf, e.cnt} || c !== 8'd255) begin
      bad++;
      $display("FAIL maxlen_result got=%b acc=%h ovf=%b cnt=%0d required acc=%h ovf=%b cnt=%0d",
               got, a, o, c, e.acc, e.ovf, e.cnt);
    end
    accept();
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    len        = '0;
    prod_in    = '0;
    prod_valid = 1'b0;
    out_ready  = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_saturation();
    test_len0();
    test_reset_mid();
    test_ignored_start();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mult_accumulator
`default_nettype wire

// File: doc/mult_accumulator.md
Name: mult_accumulator

Overview:
- Downstream consumer of the 32x32 signed Wallace-tree multiplier.
- Accumulates a programmed number of signed 64-bit products into a saturating 64-bit sum, which gives a dot-product / MAC result.
- Product input uses a valid/ready handshake; result output is held until the consumer accepts it.
- Sits between the combinational multiplier output and the result register file / host readout.

Parameters:
- PROD_W, 64, width of the signed product input; matches the multiplier output width.
- ACC_W, 64, width of the signed accumulator and result.
- LEN_W, 8, width of the programmed product count.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins an accumulation; sampled only in IDLE.
- len  input  LEN_W  number of products to accumulate; captured on the accepted start.
- prod_in  input  PROD_W  signed two's-complement product from the multiplier.
- prod_valid  input  1  prod_in is valid this cycle.
- prod_ready  output  1  block accepts prod_in this cycle.
- acc_out  output  ACC_W  signed accumulated result.
- ovf  output  1  sticky flag: saturation occurred during this accumulation.
- out_valid  output  1  acc_out and ovf are valid.
- out_ready  input  1  consumer accepts the result.
- busy  output  1  high in ACCUM and DONE.
- count  output  LEN_W  number of products accepted so far in this accumulation.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - acc_out=0, ovf=0, count=0.
  - out_valid=0, prod_ready=0, busy=0.
  - len register=0.
  - Reset mid-accumulation discards all partial state; no result is emitted.
- Handshake rules:
  - A product transfer occurs when prod_valid & prod_ready are both high at a rising edge.
  - A result transfer occurs when out_valid & out_ready are both high at a rising edge.
- State IDLE:
  - prod_ready=0, out_valid=0.
  - On start=1: capture len; clear acc_out, ovf and count.
  - If len!=0, go to ACCUM. If len==0, go directly to DONE with acc_out=0 and ovf=0.
  - start is ignored in every other state.
- State ACCUM:
  - prod_ready=1 (combinational from state).
  - On each product transfer: acc_out <= sat(acc_out + sign-extended prod_in); count <= count+1; ovf |= saturation.
  - When the transfer makes count == len, go to DONE.
  - Cycles with prod_valid=0 are stalls; state is unchanged.
- State DONE:
  - out_valid=1, prod_ready=0.
  - acc_out, ovf and count are held stable until the result transfer.
  - On the result transfer, go to IDLE. acc_out keeps its last value until the next accepted start clears it.
  - A start arriving in the same cycle as the result transfer is ignored; start is accepted from IDLE in the following cycle.
- Latency: out_valid rises the cycle after the final product transfer. The minimum accumulation takes len+1 cycles after start, plus one IDLE cycle.
- Saturation arithmetic:
  - The sum is computed ACC_W+1 bits wide.
  - If the sum exceeds 2^(ACC_W-1)-1, clamp to 0x7FFF_FFFF_FFFF_FFFF.
  - If the sum is below -2^(ACC_W-1), clamp to 0x8000_0000_0000_0000.
  - Any clamp sets ovf; ovf stays set for the rest of the accumulation.
  - Later products keep accumulating from the clamped value.
- len=2^LEN_W-1 (255) is supported; count does not wrap before DONE.
- busy = (state != IDLE).

Decomposition:
- Shared package mult_pkg holds:
  - the state enum {IDLE, ACCUM, DONE};
  - ACC_MAX / ACC_MIN constants;
  - PROD_W and ACC_W defaults, reused by the multiplier wrapper.
- One sub-module, sat_add64: a combinational signed saturating adder with inputs a and b and outputs sum and sat. It is unit-testable on its own.
- The FSM, count and handshake logic stay in mult_accumulator.

Test Plan:
- Basic sum: start with len=3; products 5, -2, 10 sent back-to-back.
  - acc_out=13, ovf=0, count=3.
  - out_valid rises the cycle after the third transfer.
- Stalls and backpressure: len=2; prod_valid toggled 1,0,0,1 with products 7 then 8; out_ready held low 4 cycles.
  - Result is 15; acc_out held stable and out_valid=1 throughout the backpressure window.
  - Transfer completes when out_ready=1.
- Saturation: len=3; products 0x7FFF_FFFF_FFFF_FFF0, 0x20, -0x10.
  - acc_out=0x7FFF_FFFF_FFFF_FFEF (clamp to max, then subtract 0x10).
  - ovf=1; negative clamp mirrored with 0x8000_0000_0000_0010 and -0x20 giving 0x8000_0000_0000_0000.
- len=0: start with len=0.
  - DONE the next cycle with acc_out=0, ovf=0, count=0.
  - prod_ready never asserted.
- Reset mid-operation: len=4; 2 products accepted, then rst pulsed asynchronously between clock edges.
  - All outputs return to 0 immediately; state is IDLE.
  - A new start with len=1 and product -9 gives acc_out=-9.
- Ignored start: start pulsed during ACCUM and in the same cycle as the DONE result transfer.
  - No restart; count and len unaffected.
  - start accepted in the next IDLE cycle.
